// File: rtl/vga_timing_monitor.sv
// vga_timing_monitor: receive-side checker for the VGA driver's HS/VS stream.
// Measures line period, HS width, lines per frame and VS width, raises sticky
// error flags, tracks lock over consecutive clean frames and counts frames.
module vga_timing_monitor #(
   parameter int   H_VISIBLE_AREA = 800,
   parameter int   H_FRONT_PORCH  = 40,
   parameter int   H_SYNC_PULSE   = 128,
   parameter int   H_BACK_PORCH   = 88,
   parameter int   V_VISIBLE_AREA = 600,
   parameter int   V_FRONT_PORCH  = 1,
   parameter int   V_SYNC_PULSE   = 4,
   parameter int   V_BACK_PORCH   = 23,
   parameter logic HSYNC_POLARITY = 1'b1,
   parameter logic VSYNC_POLARITY = 1'b1
) (
   input  logic        VGA_CLK,
   input  logic        RESET_N,
   input  logic        VGA_HS,
   input  logic        VGA_VS,
   input  logic        CLEAR,
   output logic        LOCKED,
   output logic [3:0]  ERR,
   output logic [11:0] H_TOTAL_MEAS,
   output logic [11:0] V_TOTAL_MEAS,
   output logic [15:0] FRAME_CNT
);

   localparam logic [11:0] H_TOTAL     = 12'(H_VISIBLE_AREA + H_FRONT_PORCH + H_SYNC_PULSE + H_BACK_PORCH);
   localparam logic [11:0] V_TOTAL     = 12'(V_VISIBLE_AREA + V_FRONT_PORCH + V_SYNC_PULSE + V_BACK_PORCH);
   localparam logic [11:0] H_SYNC      = 12'(H_SYNC_PULSE);
   localparam logic [11:0] V_SYNC      = 12'(V_SYNC_PULSE);
   localparam logic [11:0] CNT_MAX     = 12'hFFF;
   localparam logic [11:0] CNT_PRE_MAX = 12'hFFE;

   typedef enum logic [1:0] {
      ST_UNLOCKED = 2'd0,
      ST_GOOD1    = 2'd1,
      ST_LOCKED   = 2'd2
   } lock_state_t;

   logic        hs_act;
   logic        vs_act;
   logic [2:0]  hs_sync;
   logic [2:0]  vs_sync;
   logic        hs_rise;
   logic        hs_fall;
   logic        vs_rise;
   logic        vs_fall;
   logic        vs_level;
   logic [11:0] h_cnt;
   logic [11:0] v_cnt;
   logic [11:0] vw_cnt;
   logic        h_armed;
   logic        v_armed;
   logic        err_since_vs;
   logic [3:0]  new_err;
   lock_state_t state;
   lock_state_t state_next;

   // Normalise polarity so that 1 always means "sync active".
   assign hs_act = ~(VGA_HS ^ HSYNC_POLARITY);
   assign vs_act = ~(VGA_VS ^ VSYNC_POLARITY);

   // Edges come from stage 2 against stage 3; stage 2 is the synchronised level.
   assign hs_rise  =  hs_sync[1] & ~hs_sync[2];
   assign hs_fall  = ~hs_sync[1] &  hs_sync[2];
   assign vs_rise  =  vs_sync[1] & ~vs_sync[2];
   assign vs_fall  = ~vs_sync[1] &  vs_sync[2];
   assign vs_level =  vs_sync[1];

   // Sync pipelines; reset fills every stage with the current pin level so no
   // spurious edge appears after reset and measurement restarts unarmed.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         hs_sync <= {3{hs_act}};
         vs_sync <= {3{vs_act}};
      end else begin
         hs_sync <= {hs_sync[1:0], hs_act};
         vs_sync <= {vs_sync[1:0], vs_act};
      end
   end

   // Error events of this cycle; bit order matches ERR.
   always_comb begin
      new_err    = 4'b0000;
      new_err[0] = hs_rise ? (h_armed && (h_cnt != H_TOTAL)) : (h_cnt == CNT_PRE_MAX);
      new_err[1] = hs_fall && h_armed && (h_cnt != H_SYNC);
      new_err[2] = vs_rise && v_armed && (v_cnt != V_TOTAL);
      new_err[3] = vs_fall && v_armed && (vw_cnt != V_SYNC);
   end

   // Horizontal counter, arming and line-period capture.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         h_cnt        <= 12'd0;
         h_armed      <= 1'b0;
         H_TOTAL_MEAS <= 12'd0;
      end else if (hs_rise) begin
         h_cnt   <= 12'd1;
         h_armed <= 1'b1;
         if (h_armed) begin
            H_TOTAL_MEAS <= h_cnt;
         end else begin
            H_TOTAL_MEAS <= H_TOTAL_MEAS;
         end
      end else if (h_cnt != CNT_MAX) begin
         h_cnt <= h_cnt + 12'd1;
      end else begin
         h_cnt <= h_cnt;
      end
   end

   // Line counter, arming, frame-length capture and frame count.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         v_cnt        <= 12'd0;
         v_armed      <= 1'b0;
         V_TOTAL_MEAS <= 12'd0;
         FRAME_CNT    <= 16'd0;
      end else if (vs_rise) begin
         v_cnt   <= hs_rise ? 12'd1 : 12'd0;
         v_armed <= 1'b1;
         if (v_armed) begin
            V_TOTAL_MEAS <= v_cnt;
            FRAME_CNT    <= FRAME_CNT + 16'd1;
         end else begin
            V_TOTAL_MEAS <= V_TOTAL_MEAS;
            FRAME_CNT    <= FRAME_CNT;
         end
      end else if (hs_rise && (v_cnt != CNT_MAX)) begin
         v_cnt <= v_cnt + 12'd1;
      end else begin
         v_cnt <= v_cnt;
      end
   end

   // VS width in lines: HS edges seen while VS is active, restarted at VS end.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         vw_cnt <= 12'd0;
      end else if (vs_fall) begin
         vw_cnt <= 12'd0;
      end else if (hs_rise && vs_level && (vw_cnt != CNT_MAX)) begin
         vw_cnt <= vw_cnt + 12'd1;
      end else begin
         vw_cnt <= vw_cnt;
      end
   end

   // Sticky error flags; a new error wins over a simultaneous CLEAR.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         ERR <= 4'b0000;
      end else begin
         ERR <= (CLEAR ? 4'b0000 : ERR) | new_err;
      end
   end

   // Remembers whether any error occurred since the last VS asserting edge.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         err_since_vs <= 1'b0;
      end else if (vs_rise) begin
         err_since_vs <= 1'b0;
      end else if (|new_err) begin
         err_since_vs <= 1'b1;
      end else begin
         err_since_vs <= err_since_vs;
      end
   end

   // Lock next-state: advance on clean armed frames, drop on any error.
   always_comb begin
      state_next = state;
      if (vs_rise && v_armed) begin
         if (err_since_vs || (|new_err)) begin
            state_next = ST_UNLOCKED;
         end else begin
            case (state)
               ST_UNLOCKED: state_next = ST_GOOD1;
               ST_GOOD1:    state_next = ST_LOCKED;
               ST_LOCKED:   state_next = ST_LOCKED;
               default:     state_next = ST_UNLOCKED;
            endcase
         end
      end else if (|new_err) begin
         state_next = ST_UNLOCKED;
      end else begin
         state_next = state;
      end
   end

   // Lock state register and registered LOCKED output.
   always_ff @(posedge VGA_CLK) begin
      if (!RESET_N) begin
         state  <= ST_UNLOCKED;
         LOCKED <= 1'b0;
      end else begin
         state  <= state_next;
         LOCKED <= (state_next == ST_LOCKED);
      end
   end

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Bench for vga_timing_monitor: two instances (normal and inverted sync
// polarity) fed from one logical sync stream, checked every cycle against a
// timestamp/event model, plus hand-computed expectations at scenario ends.
module tb_vga_timing_monitor;

   localparam int HV = 16, HF = 4, H_SP = 8, HB = 4;
   localparam int VV = 10, VF = 1, V_SP = 3, VB = 2;
   localparam int HT = HV + HF + H_SP + HB;   // 32 clocks per line
   localparam int VT = VV + VF + V_SP + VB;   // 16 lines per frame
   localparam int HS_START = HV + HF;         // HS active from pixel 20
   localparam int VS_START = VV + VF;         // VS active from line 11

   logic clk = 1'b0;
   logic rst_n, clear, hs_a, vs_a;
   logic hs0, vs0, hs1, vs1;
   logic        locked0, locked1;
   logic [3:0]  err0, err1;
   logic [11:0] htm0, htm1, vtm0, vtm1;
   logic [15:0] fc0, fc1;

   int checks = 0;
   int errors = 0;

   assign hs0 = hs_a;
   assign vs0 = vs_a;
   assign hs1 = ~hs_a;
   assign vs1 = ~vs_a;

   always #5 clk = ~clk;

   vga_timing_monitor #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(H_SP), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(V_SP), .V_BACK_PORCH(VB),
      .HSYNC_POLARITY(1'b1), .VSYNC_POLARITY(1'b1)
   ) dut0 (
      .VGA_CLK(clk), .RESET_N(rst_n), .VGA_HS(hs0), .VGA_VS(vs0), .CLEAR(clear),
      .LOCKED(locked0), .ERR(err0), .H_TOTAL_MEAS(htm0), .V_TOTAL_MEAS(vtm0), .FRAME_CNT(fc0)
   );

   vga_timing_monitor #(
      .H_VISIBLE_AREA(HV), .H_FRONT_PORCH(HF), .H_SYNC_PULSE(H_SP), .H_BACK_PORCH(HB),
      .V_VISIBLE_AREA(VV), .V_FRONT_PORCH(VF), .V_SYNC_PULSE(V_SP), .V_BACK_PORCH(VB),
      .HSYNC_POLARITY(1'b0), .VSYNC_POLARITY(1'b0)
   ) dut1 (
      .VGA_CLK(clk), .RESET_N(rst_n), .VGA_HS(hs1), .VGA_VS(vs1), .CLEAR(clear),
      .LOCKED(locked1), .ERR(err1), .H_TOTAL_MEAS(htm1), .V_TOTAL_MEAS(vtm1), .FRAME_CNT(fc1)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h want=%0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Edges are located from the sampled pin history (2 clocks of sync delay,
   // one more to update); the line period is a timestamp difference.
   bit          mvalid = 1'b0;
   int          m = 0;
   int          z, hb, lines, vw, lock_lvl;
   bit          ph [8];
   bit          pv [8];
   bit          h_arm, v_arm, err_since;
   logic [11:0] e_h, e_v;
   logic [15:0] e_frame;
   logic [3:0]  e_err;
   logic        e_locked;

   function automatic int cl(input int i);
      return (i < z) ? z : i;
   endfunction

   always @(posedge clk) begin : model
      int  hpre;
      bit  hn, hp, vn, vp, hr, hf, vr, vf, was_varm;
      logic [3:0] e;
      m++;
      ph[m % 8] = hs_a;
      pv[m % 8] = vs_a;
      if (!rst_n) begin
         z = m; hb = m; h_arm = 0; v_arm = 0; lines = 0; vw = 0;
         err_since = 0; lock_lvl = 0;
         e_h = 12'd0; e_v = 12'd0; e_frame = 16'd0; e_err = 4'd0; e_locked = 1'b0;
         mvalid = 1'b1;
      end else if (mvalid) begin
         hn = ph[cl(m-2) % 8]; hp = ph[cl(m-3) % 8];
         vn = pv[cl(m-2) % 8]; vp = pv[cl(m-3) % 8];
         hr = hn & ~hp; hf = ~hn & hp; vr = vn & ~vp; vf = ~vn & vp;
         hpre = m - 1 - hb;
         if (hpre > 4095) hpre = 4095;
         e = 4'd0;
         if (hr) begin
            if (h_arm) begin
               e_h = 12'(hpre);
               if (hpre != HT) e[0] = 1'b1;
            end
            h_arm = 1; hb = m - 1;
         end else if (hpre == 4094) begin
            e[0] = 1'b1;
         end
         if (hf && h_arm && hpre != H_SP) e[1] = 1'b1;
         was_varm = v_arm;
         if (vr) begin
            if (v_arm) begin
               e_v = 12'(lines);
               if (lines != VT) e[2] = 1'b1;
               e_frame = e_frame + 16'd1;
            end
            v_arm = 1; lines = hr ? 1 : 0;
         end else if (hr && lines < 4095) begin
            lines++;
         end
         if (vf) begin
            if (v_arm && vw != V_SP) e[3] = 1'b1;
            vw = 0;
         end else if (hr && vn && vw < 4095) begin
            vw++;
         end
         e_err = (clear ? 4'd0 : e_err) | e;
         if (vr && was_varm) lock_lvl = (err_since || e != 4'd0) ? 0 : ((lock_lvl < 2) ? lock_lvl + 1 : 2);
         else if (e != 4'd0) lock_lvl = 0;
         if (vr) err_since = 0;
         else if (e != 4'd0) err_since = 1;
         e_locked = (lock_lvl == 2);
      end
   end

   // Per-cycle comparison of both instances against the model.
   always @(negedge clk) begin
      if (mvalid) begin
         chk("cyc_dut0", 64'({locked0, err0, htm0, vtm0, fc0}), 64'({e_locked, e_err, e_h, e_v, e_frame}));
         chk("cyc_dut1", 64'({locked1, err1, htm1, vtm1, fc1}), 64'({e_locked, e_err, e_h, e_v, e_frame}));
      end
   end

   // ---------------- literal expectations ----------------
   function automatic logic [15:0] field(input int d, input int w);
      logic [15:0] r;
      r = 16'd0;
      case (w)
         0: r = d ? 16'(locked1) : 16'(locked0);
         1: r = d ? 16'(err1)    : 16'(err0);
         2: r = d ? 16'(htm1)    : 16'(htm0);
         3: r = d ? 16'(vtm1)    : 16'(vtm0);
         4: r = d ? fc1          : fc0;
         default: r = 16'hDEAD;
      endcase
      return r;
   endfunction

   task automatic lit(input string nm, input int w, input logic [15:0] e);
      for (int d = 0; d < 2; d++) chk($sformatf("%s_dut%0d", nm, d), 64'(field(d, w)), 64'(e));
   endtask

   task automatic lit_zero(input string nm);
      for (int w = 0; w < 5; w++) lit($sformatf("%s_f%0d", nm, w), w, 16'd0);
   endtask

   // ---------------- stimulus ----------------
   task automatic gen_line(input int len, input int hsw, input bit vs, input int clr_at, input int rst_at);
      for (int j = 0; j < len; j++) begin
         @(posedge clk); #1;
         if (rst_at >= 0 && j == rst_at + 1) lit_zero("midreset");
         hs_a  = (j >= HS_START) && (j < HS_START + hsw);
         vs_a  = vs;
         clear = (j == clr_at);
         rst_n = !(j == rst_at);
      end
   endtask

   task automatic gen_frame(input int nl, input int vsw, input int bad_line, input int bad_len,
                            input int bad_hsw, input int clr_line, input int clr_pix,
                            input int rst_line, input int rst_pix, input bit rnd);
      for (int l = 0; l < nl; l++) begin
         int len, hsw;
         len = (l == bad_line) ? bad_len : HT;
         hsw = (l == bad_line) ? bad_hsw : H_SP;
         if (rnd) begin
            if ($urandom_range(0, 5) == 0) len = int'($urandom_range(30, 34));
            if ($urandom_range(0, 5) == 0) hsw = int'($urandom_range(7, 9));
         end
         gen_line(len, hsw, (l >= VS_START) && (l < VS_START + vsw),
                  (l == clr_line) ? clr_pix : -1, (l == rst_line) ? rst_pix : -1);
      end
   endtask

   task automatic frame_ok(input int n);
      repeat (n) gen_frame(VT, V_SP, -1, HT, H_SP, -1, 0, -1, 0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; clear = 1'b0; hs_a = 1'b0; vs_a = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      lit_zero("reset");
      rst_n = 1'b1;

      // nominal: three frames, lock on the third VS edge
      frame_ok(3);
      lit("nom_htotal", 2, 16'd32);
      lit("nom_vtotal", 3, 16'd16);
      lit("nom_err", 1, 16'd0);
      lit("nom_frames", 4, 16'd2);
      lit("nom_locked", 0, 16'd1);

      // one short line (31 clocks)
      gen_frame(VT, V_SP, 5, 31, H_SP, -1, 0, -1, 0, 1'b0);
      lit("short_err", 1, 16'h1);
      lit("short_unlocked", 0, 16'd0);
      frame_ok(2);
      lit("relock", 0, 16'd1);
      lit("sticky_err", 1, 16'h1);
      gen_frame(VT, V_SP, -1, HT, H_SP, 0, 2, -1, 0, 1'b0);
      lit("cleared_err", 1, 16'h0);

      // HS pulse one clock short
      gen_frame(VT, V_SP, 3, HT, 7, -1, 0, -1, 0, 1'b0);
      lit("hsw_err", 1, 16'h2);

      // frame one line short (clear the HS-width flag on its first line)
      gen_frame(VT - 1, V_SP, -1, HT, H_SP, 0, 2, -1, 0, 1'b0);
      frame_ok(1);
      lit("vtot_err", 1, 16'h4);
      lit("vtot_meas", 3, 16'd15);

      // VS pulse one line short
      gen_frame(VT, 2, -1, HT, H_SP, 0, 2, -1, 0, 1'b0);
      lit("vsw_err", 1, 16'h8);

      // CLEAR in the same cycle as an HS-width error: only that bit survives
      for (int l = 0; l < VT; l++)
         gen_line((l == 2) ? 31 : HT, (l == 5) ? 7 : H_SP,
                  (l >= VS_START) && (l < VS_START + V_SP), (l == 5) ? 29 : -1, -1);
      lit("clr_coincident", 1, 16'h2);

      // two clean frames relock; then hold HS inactive until saturation
      gen_frame(VT, V_SP, -1, HT, H_SP, 0, 2, -1, 0, 1'b0);
      frame_ok(1);
      lit("pre_idle_locked", 0, 16'd1);
      lit("pre_idle_err", 1, 16'd0);
      repeat (4200) begin
         @(posedge clk); #1;
         hs_a = 1'b0; vs_a = 1'b0; clear = 1'b0;
      end
      lit("sat_err", 1, 16'h1);
      lit("sat_unlocked", 0, 16'd0);
      lit("sat_htotal_kept", 2, 16'd32);

      // one-cycle reset mid-frame, then relock
      gen_frame(VT, V_SP, -1, HT, H_SP, -1, 0, 4, 5, 1'b0);
      frame_ok(2);
      lit("post_rst_err", 1, 16'd0);
      lit("post_rst_locked", 0, 16'd1);
      lit("post_rst_frames", 4, 16'd2);

      // randomized frames, checked by the model every cycle
      for (int f = 0; f < 30; f++) begin
         int nl, vsw, cl_line, rs_line;
         nl      = ($urandom_range(0, 4) == 0) ? int'($urandom_range(15, 17)) : VT;
         vsw     = ($urandom_range(0, 4) == 0) ? int'($urandom_range(2, 4)) : V_SP;
         cl_line = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         rs_line = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, nl - 1)) : -1;
         gen_frame(nl, vsw, -1, HT, H_SP, cl_line, int'($urandom_range(0, 29)),
                   rs_line, int'($urandom_range(1, 10)), 1'b1);
      end

      @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/vga_timing_monitor.md
# vga_timing_monitor

Receive-side checker for the VGA stream produced by the team's VGA driver. It samples the HS/VS outputs on the pixel clock and measures line period, HS pulse width, lines per frame and VS pulse width. It compares each measurement against the same timing parameters the driver uses, raises sticky error flags and a LOCKED indication, and exposes the last measured totals. It sits on the board beside the driver, or in simulation benches, as the self-check for any new video mode.

## Interface
- H_VISIBLE_AREA, 800, visible pixels per line
- H_FRONT_PORCH, 40, pixels
- H_SYNC_PULSE, 128, pixels
- H_BACK_PORCH, 88, pixels
- V_VISIBLE_AREA, 600, visible lines
- V_FRONT_PORCH, 1, lines
- V_SYNC_PULSE, 4, lines
- V_BACK_PORCH, 23, lines
- HSYNC_POLARITY, 1'b1, 1 = sync asserted high, 0 = asserted low
- VSYNC_POLARITY, 1'b1, same for VS
- VGA_CLK  in  1  pixel clock; single clock domain
- RESET_N  in  1  synchronous, active-low reset
- VGA_HS  in  1  horizontal sync from driver
- VGA_VS  in  1  vertical sync from driver
- CLEAR  in  1  one-cycle pulse, clears ERR
- LOCKED  out  1  two consecutive error-free frames seen
- ERR  out  4  sticky: [0] H period, [1] HS width, [2] V total, [3] VS width
- H_TOTAL_MEAS  out  12  last measured clocks between HS asserting edges
- V_TOTAL_MEAS  out  12  last measured HS edges between VS asserting edges
- FRAME_CNT  out  16  completed frames, wraps 0xFFFF→0

## Operation
- Derived totals:
  - H_TOTAL = sum of the four H parameters (1056 at defaults).
  - V_TOTAL = sum of the four V parameters (628 at defaults).
- Polarity normalisation: hs_act = ~(VGA_HS ^ HSYNC_POLARITY); vs_act likewise.
- Two register stages per sync input, then edge detect against a third stage.
  - Asserting edge: stage-3 = 0, stage-2 = 1.
  - Deasserting edge: the reverse.
- h_cnt (12 bits): 1 on an HS asserting edge, otherwise +1, saturating at 4095.
- HS asserting edge with h_armed = 1:
  - H_TOTAL_MEAS ← h_cnt.
  - If h_cnt ≠ H_TOTAL, set ERR[0].
  - h_armed is set by the first asserting edge after reset; the first edge only arms.
- HS deasserting edge: if h_cnt ≠ H_SYNC_PULSE, set ERR[1]. Skipped if h_armed = 0.
- h_cnt reaching 4095: set ERR[0] and treat as a frame error.
- Line counting:
  - v_cnt (12 bits, saturating) increments on every HS asserting edge.
  - vw_cnt increments on HS asserting edges while synchronised vs_act = 1, including the cycle of the VS asserting edge.
- VS asserting edge with v_armed = 1:
  - V_TOTAL_MEAS ← v_cnt.
  - If v_cnt ≠ V_TOTAL, set ERR[2].
  - FRAME_CNT +1.
  - v_cnt ← 0, or 1 if an HS asserting edge occurs in the same cycle.
- VS deasserting edge with v_armed = 1: if vw_cnt ≠ V_SYNC_PULSE, set ERR[3]; clear vw_cnt.
- Lock state machine:
  - States: UNLOCKED → GOOD1 → LOCKED.
  - At each armed VS asserting edge: advance one state if no error was raised since the previous VS asserting edge; otherwise go to UNLOCKED.
  - Any error event forces UNLOCKED in its update cycle.
  - LOCKED output = 1 only in state LOCKED.
- ERR bits are sticky. CLEAR zeroes them. CLEAR in the same cycle as a new error: the new error's bit ends set.
- CLEAR affects nothing besides ERR.

## Timing
- Reset: every output is 0; h_cnt, v_cnt, vw_cnt, arm flags and lock state are 0/UNLOCKED.
- Reset asserted mid-frame takes effect on the next clock edge; measurement restarts unarmed.
- Pin change → edge-detect cycle: 2 clocks. All outputs update on the clock after detect, i.e. 3 clocks after the pin change.
- Measurements are unaffected by the 3-cycle pipeline, since both edges of each measurement see equal delay.
- All outputs are registered; no combinational path from inputs.

## Test plan
- Nominal 800x600@60, defaults, 40 MHz, 3 frames:
  - H_TOTAL_MEAS = 1056 and V_TOTAL_MEAS = 628 after the 2nd VS edge.
  - LOCKED = 1 three clocks after the 3rd VS asserting edge.
  - ERR = 0; FRAME_CNT = 2.
- Locked stream, one line shortened to 1055 clocks:
  - ERR[0] = 1 and LOCKED = 0 three clocks after that HS edge.
  - LOCKED returns after two clean frames.
  - ERR[0] stays until CLEAR, then reads 0.
- HS pulse of 127 clocks → ERR[1]. Frame of 627 lines → ERR[2], V_TOTAL_MEAS = 627. VS of 3 lines → ERR[3]. In each case other ERR bits stay 0.
- HS held inactive → when h_cnt saturates at 4095, ERR[0] = 1 and LOCKED = 0; no further H_TOTAL_MEAS update.
- RESET_N low for 1 cycle mid-frame:
  - All outputs 0 next cycle.
  - First HS and VS edges afterwards raise no errors.
  - LOCKED reachable after 3 VS edges.
- HSYNC_POLARITY = VSYNC_POLARITY = 0 with inverted sync stream → same results as the nominal case. CLEAR coincident with an error → the bit remains set.
